// File: rtl/keycode_pio_pkg.sv
// Shared register map and bit positions for the keycode event PIO.
// Imported by the top and by the bench so addresses stay in one place.
package keycode_pio_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA   = 2'd0,
    ADDR_MASK   = 2'd1,
    ADDR_STATUS = 2'd2,
    ADDR_EVENT  = 2'd3
  } reg_addr_e;

  localparam int MASK_NEMPTY_BIT = 0;
  localparam int MASK_OVF_BIT    = 1;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_CNT_LSB   = 8;
  localparam int STAT_CNT_MSB   = 15;

  localparam int EVENT_VLD_BIT = 31;

endpackage

// File: rtl/keycode_event_fifo.sv
// Single-clock first-word-fall-through event FIFO; head valid whenever !empty.
// Push while full is dropped unless a pop happens in the same clk.
module keycode_event_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a pop frees the slot the simultaneous push needs
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keycode_event_pio.sv
// Avalon-MM keycode PIO: synchronises in_port, queues every change, maskable level irq.
// readdata has 1-clk latency; EVENT reads pop in the strobe clk; overflowing events are dropped.
module keycode_event_pio
  import keycode_pio_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] in_port,
  output logic              irq
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] sync_ff [SYNC_STAGES];
  logic [DATA_W-1:0] sync_q;
  logic [DATA_W-1:0] prev;
  logic              push;

  logic [DATA_W-1:0] head;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;

  logic [1:0]        mask;
  logic              overflow;
  logic              ev_rd;
  logic              wr_en;
  logic              ovf_set;
  logic              ovf_clr;
  logic [31:0]       rd_data;
  logic              unused_wdata;

  assign sync_q = sync_ff[SYNC_STAGES-1];
  assign push   = (sync_q != prev);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_ff[i] <= '0;
      prev <= '0;
    end else begin
      sync_ff[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_ff[i] <= sync_ff[i-1];
      prev <= sync_q;
    end
  end

  keycode_event_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (sync_q),
    .pop       (ev_rd),
    .head      (head),
    .empty     (empty),
    .full      (full),
    .count     (count)
  );

  // Avalon forbids read+write together; the read wins so the write is simply dropped
  assign ev_rd   = read & (address == ADDR_EVENT);
  assign wr_en   = write & ~read;
  assign ovf_set = push & full & ~ev_rd;
  assign ovf_clr = wr_en & (address == ADDR_STATUS) & writedata[STAT_OVF_BIT];
  assign unused_wdata = ^writedata[31:3];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask     <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en && address == ADDR_MASK) mask <= writedata[1:0];
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_addr_e'(address))
      ADDR_DATA:   rd_data = 32'(sync_q);
      ADDR_MASK:   rd_data[1:0] = mask;
      ADDR_STATUS: begin
        rd_data[STAT_EMPTY_BIT] = empty;
        rd_data[STAT_FULL_BIT]  = full;
        rd_data[STAT_OVF_BIT]   = overflow;
        rd_data[STAT_CNT_MSB:STAT_CNT_LSB] = 8'(count);
      end
      ADDR_EVENT: begin
        if (!empty) begin
          rd_data = 32'(head);
          rd_data[EVENT_VLD_BIT] = 1'b1;
        end
      end
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  readdata <= '0;
    else if (read) readdata <= rd_data;
  end

  assign irq = (mask[MASK_NEMPTY_BIT] & ~empty) | (mask[MASK_OVF_BIT] & overflow);

endmodule

// File: tb/tb_keycode_event_pio.sv
// Scoreboarded random bench for keycode_event_pio; reads queue their expected readdata,
// a monitor pops and compares one clk after each read strobe.
module tb_keycode_event_pio;
  import keycode_pio_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          read;
  logic          write;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [DW-1:0] in_port;
  logic          irq;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  logic [DW-1:0] mq[$];
  bit            m_ovf;
  logic [1:0]    m_mask;
  logic [DW-1:0] m_last;

  always #5 clk = ~clk;

  keycode_event_pio #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: a list of captured key values plus flags
  function automatic void m_push(input logic [DW-1:0] v);
    if (mq.size() < DEPTH) mq.push_back(v);
    else m_ovf = 1'b1;
  endfunction

  function automatic logic [31:0] m_event();
    if (mq.size() == 0) return 32'h0;
    return {16'h8000, mq.pop_front()};
  endfunction

  function automatic logic [31:0] m_status();
    return {16'h0, 8'(mq.size()), 5'b0, m_ovf, mq.size() == DEPTH, mq.size() == 0};
  endfunction

  function automatic logic m_irq();
    return (m_mask[0] && mq.size() != 0) || (m_mask[1] && m_ovf);
  endfunction

  initial begin : monitor
    logic seen;
    logic [31:0] e;
    string t;
    forever begin
      @(posedge clk);
      seen = read && reset_n;
      @(negedge clk);
      if (seen) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_read: got %h expected no read", readdata);
        end else begin
          e = exp_q.pop_front();
          t = tag_q.pop_front();
          chk(t, readdata, e);
        end
      end
    end
  end

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string name);
    address = a;
    read    = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back(name);
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic rd_event(input string name);
    rd(ADDR_EVENT, m_event(), name);
    chk({name, "_irq"}, 32'(irq), 32'(m_irq()));
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(negedge clk);
    write = 1'b0;
    if (a == ADDR_MASK) m_mask = d[1:0];
    if (a == ADDR_STATUS && d[2]) m_ovf = 1'b0;
  endtask

  task automatic set_in(input logic [DW-1:0] v);
    in_port = v;
    if (v != m_last) begin
      m_push(v);
      m_last = v;
    end
    repeat (4) @(negedge clk);
  endtask

  // new value's push lands in the same clk as an EVENT read
  task automatic push_and_read(input logic [DW-1:0] v, input string name);
    logic [31:0] e;
    in_port = v;
    @(negedge clk);
    @(negedge clk);
    e = m_event();
    m_push(v);
    m_last = v;
    rd(ADDR_EVENT, e, name);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset(input logic [DW-1:0] v, input string name);
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk({name, "_rdata"}, readdata, 32'h0);
    chk({name, "_irq"}, 32'(irq), 32'h0);
    in_port = v;
    mq.delete();
    m_ovf  = 1'b0;
    m_mask = 2'b00;
    m_last = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    if (v != m_last) begin
      m_push(v);
      m_last = v;
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [DW-1:0] s;
    logic [DW-1:0] g;
    reset_n = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0; in_port = '0;
    mq.delete(); m_ovf = 1'b0; m_mask = 2'b00; m_last = '0;
    #2;
    chk("reset_rdata", readdata, 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    rd(ADDR_STATUS, m_status(), "t1_status");
    chk("t1_irq", 32'(irq), 32'h0);

    // irq rises three clks after in_port changes
    wr(ADDR_MASK, 32'h1);
    in_port = 16'h0004;
    @(negedge clk); @(negedge clk);
    chk("t2_irq_early", 32'(irq), 32'h0);
    @(negedge clk);
    chk("t2_irq_3clk", 32'(irq), 32'h1);
    m_push(16'h0004); m_last = 16'h0004;
    rd_event("t2_event");
    chk("t2_event_lit", readdata, 32'h8000_0004);

    // overflow: nine changes into eight slots
    for (int i = 0; i < 9; i++) set_in(16'h0100 + 16'(i));
    rd(ADDR_STATUS, m_status(), "t3_status_full");
    wr(ADDR_MASK, 32'h2);
    chk("t3_irq_ovf", 32'(irq), 32'(m_irq()));
    for (int i = 0; i < 9; i++) rd_event($sformatf("t3_event%0d", i));
    chk("t3_last_read_zero", readdata, 32'h0);
    wr(ADDR_STATUS, 32'h4);
    rd(ADDR_STATUS, m_status(), "t3_status_clr");
    chk("t3_irq_clr", 32'(irq), 32'(m_irq()));

    // simultaneous push and EVENT read: empty, then full
    push_and_read(16'h0A00, "t4_empty_pushread");
    rd(ADDR_STATUS, m_status(), "t4_status_one");
    for (int i = 1; i < DEPTH; i++) set_in(16'h0A00 + 16'(i));
    push_and_read(16'h0BBB, "t4_full_pushread");
    rd(ADDR_STATUS, m_status(), "t4_status_full");
    while (mq.size() != 0) rd_event("t4_drain");

    // glitch straddling one rising edge yields two events
    s = 16'($urandom_range(1, 65535));
    set_in(s);
    g = s ^ 16'h00F0;
    @(negedge clk);
    #3 in_port = g;
    #4 in_port = s;
    m_push(g); m_push(s);
    @(negedge clk);
    repeat (5) @(negedge clk);
    rd(ADDR_DATA, 32'(m_last), "t5_data_stable");
    rd(ADDR_STATUS, m_status(), "t5_status_glitch");

    // reset in the middle of an event burst
    wr(ADDR_MASK, 32'h3);
    for (int i = 0; i < 3; i++) begin
      in_port = 16'($urandom_range(1, 65535));
      @(negedge clk);
    end
    do_reset(16'h0000, "t5_rst");
    rd(ADDR_MASK, 32'h0, "t5_mask_after_rst");
    rd(ADDR_STATUS, m_status(), "t5_status_after_rst");
    do_reset(16'h1234, "t5_rst_nz");
    rd(ADDR_STATUS, m_status(), "t5_status_nz_release");

    // random mix against the model
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0, 1: set_in(($urandom_range(0, 3) == 0) ? m_last : 16'($urandom));
        2: rd_event("rnd_event");
        3: rd(ADDR_STATUS, m_status(), "rnd_status");
        4: if ($urandom_range(0, 1) == 1) rd(ADDR_DATA, 32'(m_last), "rnd_data");
           else rd(ADDR_MASK, 32'(m_mask), "rnd_mask");
        default: begin
          case ($urandom_range(0, 2))
            0: wr(ADDR_MASK, $urandom);
            1: wr(ADDR_STATUS, $urandom);
            default: wr(($urandom_range(0, 1) == 1) ? ADDR_EVENT : ADDR_DATA, $urandom);
          endcase
        end
      endcase
      chk("rnd_irq", 32'(irq), 32'(m_irq()));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
